clk_freq_monitor: RTL and testbench

Measures a generated clock (for example a divider output) against the system clock `inclk` and checks whether its frequency is within a programmed band.
- `mon_clk` is sampled as asynchronous data, synchronised, and its rising edges are counted over fixed windows of WIN_LEN `inclk` cycles.
- Each window produces a count, an in-range flag, a stall flag and a debounced `locked` indication.
- It is the checking counterpart to the clock generator lib and sits beside the divider instances in the clock/reset block.

---
 rtl/clk_freq_monitor.sv | 94 +++++++++
 tb/tb_clk_freq_monitor.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor: counts synchronised mon_clk rising edges over fixed inclk windows and flags count range, stall and lock
//   inclk     system clock, all logic on its rising edge
//   rst       asynchronous active-high reset
//   en        measurement enable (level)
//   mon_clk   clock under test, asynchronous to inclk, below inclk/2
//   exp_min   inclusive lower bound of the accepted count
//   exp_max   inclusive upper bound of the accepted count
//   edge_cnt  count from the last completed window
//   cnt_valid one-cycle pulse when edge_cnt updates
//   in_range  exp_min <= edge_cnt <= exp_max for the last window
//   stalled   last window counted zero edges
//   locked    LOCK_WIN consecutive in-range windows seen
module clk_freq_monitor #(
  parameter int WIN_LEN     = 1024,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_WIN    = 4
) (
  input  logic             inclk,
  input  logic             rst,
  input  logic             en,
  input  logic             mon_clk,
  input  logic [CNT_W-1:0] exp_min,
  input  logic [CNT_W-1:0] exp_max,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cnt_valid,
  output logic             in_range,
  output logic             stalled,
  output logic             locked
);
  localparam int WW = $clog2(WIN_LEN);
  localparam int AW = $clog2(SYNC_STAGES + 2);
  localparam int LW = $clog2(LOCK_WIN + 1);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic hist, rise, term, ir;
  logic [WW-1:0] win_cnt;
  logic [AW-1:0] arm_cnt;
  logic [CNT_W-1:0] acc, fin;
  logic [LW-1:0] lock_cnt, lock_nxt;
  assign rise = sync[SYNC_STAGES-1] & ~hist;
  always_ff @(posedge inclk or posedge rst)
    if (rst) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], mon_clk};
      hist <= sync[SYNC_STAGES-1];
    end
  always_ff @(posedge inclk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // ARM holds SYNC_STAGES+1 cycles so stale synchroniser contents never reach the count
  always_comb begin
    state_nxt = !en ? IDLE :
                state == IDLE ? ARM :
                (state == ARM && arm_cnt == AW'(SYNC_STAGES)) ? MEASURE : state;
    term      = state == MEASURE && en && win_cnt == WW'(WIN_LEN - 1);
    fin       = (rise && acc != '1) ? acc + 1'b1 : acc;
    ir        = exp_min <= fin && fin <= exp_max;
    lock_nxt  = !ir ? '0 : lock_cnt == LW'(LOCK_WIN) ? lock_cnt : lock_cnt + 1'b1;
  end
  always_ff @(posedge inclk or posedge rst)
    if (rst) begin
      arm_cnt   <= '0;
      win_cnt   <= '0;
      acc       <= '0;
      lock_cnt  <= '0;
      edge_cnt  <= '0;
      cnt_valid <= 1'b0;
      in_range  <= 1'b0;
      stalled   <= 1'b0;
      locked    <= 1'b0;
    end else begin
      cnt_valid <= term;
      arm_cnt   <= state == ARM ? arm_cnt + 1'b1 : '0;
      // terminal cycle restarts the window with no gap; fin already includes its rise
      win_cnt   <= (state == MEASURE && !term) ? win_cnt + 1'b1 : '0;
      acc       <= (state == MEASURE && !term) ? fin : '0;
      if (!en) begin
        lock_cnt <= '0;
        in_range <= 1'b0;
        stalled  <= 1'b0;
        locked   <= 1'b0;
      end else if (term) begin
        edge_cnt <= fin;
        in_range <= ir;
        stalled  <= fin == '0;
        lock_cnt <= lock_nxt;
        locked   <= lock_nxt == LW'(LOCK_WIN);
      end
    end
endmodule

// File: tb/tb_clk_freq_monitor.sv
// tb_clk_freq_monitor: randomized self-checking bench for clk_freq_monitor against a window-level edge-count model
module tb_clk_freq_monitor;
  localparam int WIN = 64;
  localparam int S   = 2;
  localparam int LWN = 4;
  logic inclk = 0, rst = 1, en = 0, en_s = 0, mon_clk = 0;
  logic [15:0] exp_min = 0, exp_max = 0, edge_cnt;
  logic cnt_valid, in_range, stalled, locked;
  logic [3:0] exp_min_s = 0, exp_max_s = 0, edge_cnt_s;
  logic cnt_valid_s, in_range_s, stalled_s, locked_s;
  int checks = 0, failures = 0;
  int cyc = 0, mode = 0, hp = 4, ph = 0, run_cnt = 0;
  logic [15:0] last_cnt = 0;
  bit smp [0:65535];
  clk_freq_monitor #(.WIN_LEN(WIN), .CNT_W(16), .SYNC_STAGES(S), .LOCK_WIN(LWN)) dut (
    .inclk(inclk), .rst(rst), .en(en), .mon_clk(mon_clk), .exp_min(exp_min), .exp_max(exp_max),
    .edge_cnt(edge_cnt), .cnt_valid(cnt_valid), .in_range(in_range), .stalled(stalled), .locked(locked));
  clk_freq_monitor #(.WIN_LEN(WIN), .CNT_W(4), .SYNC_STAGES(S), .LOCK_WIN(LWN)) dut_s (
    .inclk(inclk), .rst(rst), .en(en_s), .mon_clk(mon_clk), .exp_min(exp_min_s), .exp_max(exp_max_s),
    .edge_cnt(edge_cnt_s), .cnt_valid(cnt_valid_s), .in_range(in_range_s), .stalled(stalled_s), .locked(locked_s));
  always #5 inclk = ~inclk;
  always @(posedge inclk) begin
    smp[cyc] <= mon_clk;
    cyc <= cyc + 1;
  end
  always @(negedge inclk)
    case (mode)
      1: begin
        ph = ph + 1;
        if (ph >= hp) begin
          ph = 0;
          mon_clk = ~mon_clk;
        end
      end
      2: begin
        if (ph <= 0) begin
          mon_clk = ~mon_clk;
          ph = $urandom_range(1, 5);
        end
        ph = ph - 1;
      end
      3: ;
      default: mon_clk = 0;
    endcase
  // A mon_clk level sampled at edge k is seen as a rise S edges later; ARM spans S+1 edges after the enabling edge e
  function automatic int count_rises(int e, int w);
    int n = 0;
    for (int m = e + S + 2 + w * WIN; m <= e + S + 1 + (w + 1) * WIN; m++)
      if (smp[m-S] && !smp[m-S-1]) n++;
    return n;
  endfunction
  task automatic enable(output int e);
    @(negedge inclk);
    en = 1;
    e = cyc;
  endtask
  task automatic drop_en();
    @(negedge inclk);
    en = 0;
    run_cnt = 0;
    repeat (3) @(negedge inclk);
  endtask
  task automatic check_window(input string nm, input int e, input int w);
    int t, n, k;
    bit ir;
    t = e + S + 1 + (w + 1) * WIN;
    k = 0;
    do begin
      @(negedge inclk);
      k++;
    end while (!cnt_valid && k < 3 * WIN);
    checks++;
    if (!cnt_valid) begin
      failures++;
      $display("FAIL %s w%0d timeout: no cnt_valid within %0d cycles", nm, w, k);
      return;
    end
    checks++;
    if (cyc - 1 !== t) begin
      failures++;
      $display("FAIL %s w%0d pulse_time: got edge %0d expected %0d", nm, w, cyc - 1, t);
    end
    n = count_rises(e, w);
    ir = n >= int'(exp_min) && n <= int'(exp_max);
    run_cnt = ir ? run_cnt + 1 : 0;
    last_cnt = 16'(n);
    checks++;
    if (edge_cnt !== 16'(n)) begin
      failures++;
      $display("FAIL %s w%0d edge_cnt: got %0d expected %0d", nm, w, edge_cnt, n);
    end
    checks++;
    if (in_range !== ir) begin
      failures++;
      $display("FAIL %s w%0d in_range: got %b expected %b", nm, w, in_range, ir);
    end
    checks++;
    if (stalled !== (n == 0)) begin
      failures++;
      $display("FAIL %s w%0d stalled: got %b expected %b", nm, w, stalled, n == 0);
    end
    checks++;
    if (locked !== (run_cnt >= LWN)) begin
      failures++;
      $display("FAIL %s w%0d locked: got %b expected %b", nm, w, locked, run_cnt >= LWN);
    end
    @(negedge inclk);
    checks++;
    if (cnt_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s w%0d pulse_width: cnt_valid still %b", nm, w, cnt_valid);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge inclk);
    checks++;
    if ({edge_cnt, cnt_valid, in_range, stalled, locked} !== '0) begin
      failures++;
      $display("FAIL reset main: got cnt=%0d v=%b r=%b s=%b l=%b expected all 0", edge_cnt, cnt_valid, in_range, stalled, locked);
    end
    checks++;
    if ({edge_cnt_s, cnt_valid_s, in_range_s, stalled_s, locked_s} !== '0) begin
      failures++;
      $display("FAIL reset sat: got cnt=%0d v=%b r=%b s=%b l=%b expected all 0", edge_cnt_s, cnt_valid_s, in_range_s, stalled_s, locked_s);
    end
    rst = 0;
  endtask
  task automatic test_lock_and_stall();
    int e;
    @(negedge inclk);
    ph = 0;
    hp = 4;
    mon_clk = 0;
    mode = 1;
    exp_min = 7;
    exp_max = 9;
    enable(e);
    for (int w = 0; w < 5; w++) check_window("lock", e, w);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL lock_final: got %b expected 1", locked);
    end
    mode = 0;
    check_window("stall", e, 5);
    check_window("stall", e, 6);
    checks++;
    if ({edge_cnt, stalled, in_range, locked} !== {16'd0, 3'b100}) begin
      failures++;
      $display("FAIL stall_final: got cnt=%0d s=%b r=%b l=%b expected 0 1 0 0", edge_cnt, stalled, in_range, locked);
    end
  endtask
  task automatic test_boundary();
    int e, t;
    drop_en();
    ph = 0;
    hp = 4;
    mon_clk = 0;
    mode = 1;
    exp_min = 8;
    exp_max = 8;
    enable(e);
    check_window("bound_eq", e, 0);
    check_window("bound_eq", e, 1);
    checks++;
    if ({edge_cnt, in_range} !== {16'd8, 1'b1}) begin
      failures++;
      $display("FAIL bound_eq: got cnt=%0d r=%b expected 8 1", edge_cnt, in_range);
    end
    exp_min = 9;
    check_window("bound_inv", e, 2);
    checks++;
    if (in_range !== 1'b0) begin
      failures++;
      $display("FAIL bound_inv in_range: got %b expected 0", in_range);
    end
    mode = 3;
    mon_clk = 0;
    exp_min = 0;
    exp_max = 100;
    check_window("term_pre", e, 3);
    t = e + S + 1 + 5 * WIN;
    while (cyc < t - S) @(negedge inclk);
    mon_clk = 1;
    @(negedge inclk);
    mon_clk = 0;
    check_window("term_rise", e, 4);
    checks++;
    if (edge_cnt !== 16'd1) begin
      failures++;
      $display("FAIL term_rise count: got %0d expected 1", edge_cnt);
    end
    check_window("term_next", e, 5);
    checks++;
    if (edge_cnt !== 16'd0) begin
      failures++;
      $display("FAIL term_next carry: got %0d expected 0", edge_cnt);
    end
  endtask
  task automatic test_en_drop_and_rst();
    int e, p;
    drop_en();
    ph = 0;
    hp = 4;
    mon_clk = 0;
    mode = 1;
    exp_min = 7;
    exp_max = 9;
    enable(e);
    for (int w = 0; w < 4; w++) check_window("pre_drop", e, w);
    repeat (29) @(negedge inclk);
    en = 0;
    run_cnt = 0;
    @(negedge inclk);
    checks++;
    if ({locked, in_range, stalled} !== 3'b000 || edge_cnt !== last_cnt) begin
      failures++;
      $display("FAIL en_drop: got l=%b r=%b s=%b cnt=%0d expected 0 0 0 cnt=%0d", locked, in_range, stalled, edge_cnt, last_cnt);
    end
    p = 0;
    repeat (100) begin
      @(negedge inclk);
      if (cnt_valid) p++;
    end
    checks++;
    if (p != 0) begin
      failures++;
      $display("FAIL en_drop pulses: got %0d expected 0", p);
    end
    enable(e);
    check_window("reenable", e, 0);
    repeat (20) @(negedge inclk);
    rst = 1;
    #1;
    checks++;
    if ({edge_cnt, cnt_valid, in_range, stalled, locked} !== '0) begin
      failures++;
      $display("FAIL mid_rst: got cnt=%0d v=%b r=%b s=%b l=%b expected all 0", edge_cnt, cnt_valid, in_range, stalled, locked);
    end
    @(negedge inclk);
    rst = 0;
    e = cyc;
    run_cnt = 0;
    check_window("post_rst", e, 0);
  endtask
  task automatic test_saturate();
    int e, k, n;
    drop_en();
    ph = 0;
    hp = 1;
    mon_clk = 0;
    mode = 1;
    exp_min_s = 0;
    exp_max_s = 15;
    @(negedge inclk);
    en_s = 1;
    e = cyc;
    for (int w = 0; w < 2; w++) begin
      k = 0;
      do begin
        @(negedge inclk);
        k++;
      end while (!cnt_valid_s && k < 3 * WIN);
      n = count_rises(e, w);
      checks++;
      if (!cnt_valid_s || cyc - 1 != e + S + 1 + (w + 1) * WIN) begin
        failures++;
        $display("FAIL sat w%0d pulse: valid=%b edge %0d expected %0d", w, cnt_valid_s, cyc - 1, e + S + 1 + (w + 1) * WIN);
      end
      checks++;
      if (edge_cnt_s !== 4'(n > 15 ? 15 : n) || edge_cnt_s !== 4'd15 || in_range_s !== 1'b1) begin
        failures++;
        $display("FAIL sat w%0d: got cnt=%0d r=%b expected 15 1 (raw %0d)", w, edge_cnt_s, in_range_s, n);
      end
    end
    @(negedge inclk);
    en_s = 0;
    mode = 0;
  endtask
  task automatic test_random();
    int e, lo;
    drop_en();
    for (int w = 0; w < 10; w++) begin
      mode = $urandom_range(1, 4) == 1 ? 2 : 1;
      hp = $urandom_range(2, 6);
      lo = $urandom_range(0, 2) != 0 ? 32 / hp - 1 : $urandom_range(0, 20);
      exp_min = 16'(lo);
      exp_max = 16'(lo + $urandom_range(0, 4) - 1 < 0 ? 0 : lo + $urandom_range(0, 4) - 1);
      if (w == 0) enable(e);
      check_window("random", e, w);
    end
    mode = 0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_lock_and_stall();
    test_boundary();
    test_en_drop_and_rst();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
